// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, bit indices and RX FSM encoding for uart_mmio
package uart_mmio_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_DROP    = 4;
    localparam int ST_RX_OVERRUN = 5;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_CLEAR_BIT = 8;

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_POP  = 1'b1;

    function automatic logic [31:0] data_word(input logic valid, input logic [7:0] b);
        return {valid, 23'b0, b};
    endfunction

endpackage

// File: rtl/uart_mmio_fifo.sv
// rtl/uart_mmio_fifo.sv - byte_fifo: synchronous 8-bit FIFO with wrap-bit pointers
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART peripheral: TX/RX FIFOs, status/control registers, irq
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq,
    output logic        tx_available,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    input  logic        rx_available,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    input  logic        rx_ack
);
    logic [3:0]  reg_addr;
    logic        wr_data, wr_ctrl, rd_pop;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]  tx_head, rx_head;
    logic        rx_push;
    logic [31:0] status_w;

    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        tx_drop_q, tx_drop_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic [0:0]  state_q, state_d;

    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:9]};

    assign reg_addr = {bus_addr[3:2], 2'b00};
    assign wr_data  = bus_we && (reg_addr == ADDR_DATA);
    assign wr_ctrl  = bus_we && (reg_addr == ADDR_CTRL);
    assign rd_pop   = bus_re && (reg_addr == ADDR_DATA) && !rx_empty;
    assign rx_push  = (state_q == RX_POP) && rx_ack;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .din   (bus_wdata[7:0]),
        .pop   (tx_ack),
        .head  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rd_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    always_comb begin
        status_w                = '0;
        status_w[ST_TX_EMPTY]   = tx_empty;
        status_w[ST_TX_FULL]    = tx_full;
        status_w[ST_RX_EMPTY]   = rx_empty;
        status_w[ST_RX_FULL]    = rx_full;
        status_w[ST_TX_DROP]    = tx_drop_q;
        status_w[ST_RX_OVERRUN] = rx_ovr_q;
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        tx_drop_d = tx_drop_q;
        rx_ovr_d  = rx_ovr_q;
        rdata_d   = rdata_q;
        state_d   = state_q;

        if (wr_ctrl) begin
            ctrl_d = bus_wdata[1:0];
            if (bus_wdata[CTRL_CLEAR_BIT]) begin
                tx_drop_d = 1'b0;
                rx_ovr_d  = 1'b0;
            end
        end
        // A full TX FIFO only rejects the write if the uart is not taking the head this cycle.
        if (wr_data && tx_full && !tx_ack) tx_drop_d = 1'b1;
        if (rx_available && rx_full)       rx_ovr_d  = 1'b1;

        if (bus_re) begin
            case (reg_addr)
                ADDR_DATA:   rdata_d = rx_empty ? 32'h0 : data_word(1'b1, rx_head);
                ADDR_STATUS: rdata_d = status_w;
                ADDR_CTRL:   rdata_d = {30'b0, ctrl_q};
                default:     rdata_d = 32'h0;
            endcase
        end

        case (state_q)
            RX_IDLE: if (rx_available && !rx_full) state_d = RX_POP;
            RX_POP:  if (rx_ack) state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            ctrl_q    <= '0;
            tx_drop_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
            state_q   <= RX_IDLE;
        end else begin
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            tx_drop_q <= tx_drop_d;
            rx_ovr_q  <= rx_ovr_d;
            state_q   <= state_d;
        end
    end

    assign bus_rdata    = rdata_q;
    assign tx_available = !tx_empty;
    assign tx_data      = tx_head;
    assign rx_pop       = (state_q == RX_POP);
    assign irq          = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) || (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty);

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio with queue-based reference model
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  bus_addr;
    logic        bus_we, bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic        tx_available;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        rx_available;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        rx_ack;

    always #5 clk = ~clk;

    uart_mmio #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .irq          (irq),
        .tx_available (tx_available),
        .tx_data      (tx_data),
        .tx_ack       (tx_ack),
        .rx_available (rx_available),
        .rx_data      (rx_data),
        .rx_pop       (rx_pop),
        .rx_ack       (rx_ack)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as queues, flags and CTRL as plain bits.
    logic [31:0] rd_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_m[$];
    int          tx_cnt;
    bit          drop_m, ovr_m;
    bit [1:0]    ctrl_m;

    // uart-side behaviour knobs and holding register.
    bit          tx_stall, tx_force, rx_rand;
    bit          hold_valid;
    logic [7:0]  hold_byte;
    logic        re_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (re_seen) begin
                if (rd_q.size() == 0) fail_now("bus_rdata_unexpected");
                else check("bus_rdata", bus_rdata, rd_q.pop_front());
            end
            if (tx_available && tx_ack) begin
                if (tx_exp_q.size() == 0) fail_now("tx_data_unexpected");
                else check("tx_data", {24'b0, tx_data}, {24'b0, tx_exp_q.pop_front()});
            end
        end
        re_seen <= bus_re;
    end

    task automatic tick();
        int          pre_tx, pre_rx;
        logic [31:0] exp;
        bit          txp, acked;
        logic [3:0]  a;
        a      = {bus_addr[3:2], 2'b00};
        tx_ack = tx_available && !tx_stall && (tx_force || ($urandom_range(0, 1) == 1));
        rx_available = hold_valid;
        rx_data      = hold_byte;
        rx_ack       = rx_pop && hold_valid && ($urandom_range(0, 3) != 0);
        acked        = rx_ack;

        pre_tx = tx_cnt;
        pre_rx = rx_m.size();
        if (bus_re) begin
            if (a == ADDR_DATA)        exp = (pre_rx > 0) ? {1'b1, 23'b0, rx_m[0]} : 32'h0;
            else if (a == ADDR_STATUS) exp = {26'b0, ovr_m, drop_m, pre_rx == 16, pre_rx == 0,
                                              pre_tx == 16, pre_tx == 0};
            else if (a == ADDR_CTRL)   exp = {30'b0, ctrl_m};
            else                       exp = 32'h0;
            rd_q.push_back(exp);
        end
        txp = tx_ack && (pre_tx > 0);
        if (bus_we && a == ADDR_DATA) begin
            if (pre_tx < 16 || txp) begin
                tx_exp_q.push_back(bus_wdata[7:0]);
                tx_cnt++;
            end else begin
                drop_m = 1'b1;
            end
        end
        if (bus_we && a == ADDR_CTRL) begin
            ctrl_m = bus_wdata[1:0];
            if (bus_wdata[8]) begin
                drop_m = 1'b0;
                ovr_m  = 1'b0;
            end
        end
        if (rx_available && pre_rx == 16) ovr_m = 1'b1;
        if (txp) tx_cnt--;
        if (bus_re && a == ADDR_DATA && pre_rx > 0) void'(rx_m.pop_front());
        if (acked) rx_m.push_back(rx_data);

        @(posedge clk);
        #1;
        tx_ack = 1'b0;
        rx_ack = 1'b0;
        bus_we = 1'b0;
        bus_re = 1'b0;
        if (acked) begin
            hold_valid = 1'b0;
            check("rx_pop_after_ack", {31'b0, rx_pop}, 32'h0);
        end
        if (!hold_valid && rx_rand && $urandom_range(0, 3) == 0) begin
            hold_valid = 1'b1;
            hold_byte  = 8'($urandom);
        end
        check("irq", {31'b0, irq},
              {31'b0, (ctrl_m[0] && rx_m.size() > 0) || (ctrl_m[1] && tx_cnt == 0)});
        check("tx_available", {31'b0, tx_available}, {31'b0, tx_cnt > 0});
        if (rx_m.size() == 16) check("rx_pop_when_full", {31'b0, rx_pop}, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        bus_re = 1'b1; bus_addr = a;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_hold(input int limit, input string name);
        for (int i = 0; i < limit && hold_valid; i++) tick();
        if (hold_valid) fail_now(name);
    endtask

    task automatic drain_tx();
        tx_stall = 1'b0;
        for (int i = 0; i < 200 && tx_cnt > 0; i++) tick();
        if (tx_cnt != 0) fail_now("tx_drain_timeout");
        idle(2);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; tx_ack = 1'b0; rx_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_cnt = 0; drop_m = 1'b0; ovr_m = 1'b0; ctrl_m = 2'b0;
        rx_m.delete(); tx_exp_q.delete(); rd_q.delete();
        check("rst_bus_rdata", bus_rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_tx_available", {31'b0, tx_available}, 32'h0);
        check("rst_rx_pop", {31'b0, rx_pop}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; bus_addr = '0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
        tx_ack = 1'b0; rx_available = 1'b0; rx_data = '0; rx_ack = 1'b0;
        tx_stall = 1'b1; tx_force = 1'b0; rx_rand = 1'b0; hold_valid = 1'b0; hold_byte = '0;
        repeat (2) @(posedge clk);
        do_reset();
        rd(ADDR_STATUS);
        rd(ADDR_CTRL);

        // TX order
        tx_stall = 1'b1;
        wr(ADDR_DATA, 32'h41); wr(ADDR_DATA, 32'h42); wr(ADDR_DATA, 32'h43);
        idle(2);
        drain_tx();
        rd(ADDR_STATUS);

        // TX full, drop, clear, then a write alongside tx_ack on a full FIFO
        tx_stall = 1'b1;
        for (int i = 0; i < 17; i++) wr(ADDR_DATA, 32'h60 + i);
        rd(ADDR_STATUS);
        wr(ADDR_CTRL, 32'h100);
        rd(ADDR_STATUS);
        tx_stall = 1'b0; tx_force = 1'b1;
        wr(ADDR_DATA, 32'h99);
        tx_stall = 1'b1; tx_force = 1'b0;
        rd(ADDR_STATUS);
        drain_tx();

        // RX pop
        hold_valid = 1'b1; hold_byte = 8'h5A;
        wait_hold(20, "rx_pop_timeout");
        idle(1);
        rd(ADDR_STATUS);
        rd(ADDR_DATA);
        rd(ADDR_DATA);

        // RX overrun
        for (int i = 0; i < 16; i++) begin
            hold_valid = 1'b1; hold_byte = 8'($urandom);
            wait_hold(20, "rx_fill_timeout");
        end
        hold_valid = 1'b1; hold_byte = 8'hC3;
        idle(5);
        rd(ADDR_STATUS);
        rd(ADDR_DATA);
        wait_hold(20, "rx_pending_timeout");
        rd(ADDR_STATUS);
        for (int i = 0; i < 17; i++) rd(ADDR_DATA);
        wr(ADDR_CTRL, 32'h100);
        rd(ADDR_STATUS);

        // IRQ on RX data
        wr(ADDR_CTRL, 32'h1);
        hold_valid = 1'b1; hold_byte = 8'h3C;
        wait_hold(20, "irq_rx_timeout");
        idle(1);
        rd(ADDR_DATA);
        idle(1);
        wr(ADDR_CTRL, 32'h2);
        idle(2);
        wr(ADDR_CTRL, 32'h0);

        // Reset mid-operation with both FIFOs half full
        tx_stall = 1'b1;
        for (int i = 0; i < 8; i++) wr(ADDR_DATA, 32'hA0 + i);
        for (int i = 0; i < 8; i++) begin
            hold_valid = 1'b1; hold_byte = 8'hB0 + 8'(i);
            wait_hold(20, "rx_half_timeout");
        end
        wr(ADDR_CTRL, 32'h3);
        do_reset();
        rd(ADDR_STATUS);
        idle(2);

        // Randomized traffic
        rx_rand = 1'b1;
        for (int n = 0; n < 900; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0) tx_stall = ~tx_stall;
            bus_addr  = 4'($urandom_range(0, 3));
            bus_wdata = $urandom;
            case (r)
                0, 1, 2: begin bus_we = 1'b1; bus_addr[3:2] = 2'd0; end
                3, 4, 5: begin bus_re = 1'b1; bus_addr[3:2] = 2'd0; end
                6:       begin bus_re = 1'b1; bus_addr[3:2] = 2'd1; end
                7:       begin bus_re = 1'b1; bus_addr[3:2] = 2'($urandom_range(2, 3)); end
                8:       begin
                             bus_we = 1'b1; bus_addr[3:2] = 2'($urandom_range(2, 3));
                             bus_wdata[8] = ($urandom_range(0, 3) == 0);
                             if ($urandom_range(0, 1) == 1) bus_re = 1'b1;
                         end
                default: ;
            endcase
            tick();
        end
        rx_rand = 1'b0;
        drain_tx();
        wait_hold(20, "rx_final_timeout");
        for (int i = 0; i < 17; i++) rd(ADDR_DATA);
        rd(ADDR_STATUS);
        idle(3);
        if (rd_q.size() != 0) fail_now("rd_queue_leftover");
        if (tx_exp_q.size() != 0) fail_now("tx_queue_leftover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

endmodule
